dmem_ctrl: RTL
==============

// Module: dmem_ctrl
// PURPOSE
//  Data-memory access controller directly downstream of the MEM stage. Takes one load/store
//  request per instruction, checks alignment, drives a word-wide valid/ready data bus with
//  byte enables, stalls the pipeline until the bus completes, and returns the extended load
//  result plus destination register to MEM/WB. A timeout counter aborts hung transactions.
// PARAMETERS
//  TIMEOUT_CYC  255  bus cycles waited for bus_ready before abort (1..1023)
// PORTS
//  clk             in   1   system clock, all state on rising edge
//  rst             in   1   asynchronous, active-low reset
//  req_valid       in   1   MEM stage presents a load/store this cycle
//  req_we          in   1   1=store, 0=load
//  req_size        in   2   00 byte, 01 half, 10 word; 11 illegal (treated as misaligned)
//  req_signed      in   1   loads: sign-extend (1) / zero-extend (0)
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data, right-justified
//  req_wreg_addr   in   5   load destination register
//  stall_o         out  1   freeze IF..MEM while request in flight
//  resp_valid      out  1   one-cycle pulse: load data valid
//  resp_rdata      out  32  extended load data
//  resp_wreg_addr  out  5   destination of completing load
//  misalign_o      out  1   one-cycle pulse: request rejected (alignment/size)
//  bus_err_o       out  1   one-cycle pulse: transaction aborted on timeout
//  bus_req         out  1   bus request, registered
//  bus_we          out  1   bus write strobe, registered
//  bus_addr        out  32  word address {req_addr[31:2],2'b00}, registered
//  bus_wdata       out  32  store data replicated into byte lanes, registered
//  bus_be          out  4   byte enables (loads: lanes read), registered
//  bus_ready       in   1   bus completes current beat
//  bus_rdata       in   32  read word, valid when bus_ready
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; bus_req, bus_we, resp_valid, misalign_o, bus_err_o,
//   stall_o = 0; bus_addr, bus_wdata, bus_be, resp_rdata, resp_wreg_addr, timer = 0.
//   Reset mid-transaction drops bus_req immediately; no response is produced.
//  States: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: req_valid & aligned -> latch req, set bus_req=1, goto BUSY. stall_o=1 combinationally
//   in this cycle. Aligned: byte any addr; half addr[0]=0; word addr[1:0]=0; size 11 never.
//   req_valid & !aligned -> misalign_o=1 this cycle (combinational), stall_o=0, stay IDLE.
//  BUSY: stall_o=1; bus_req held with stable addr/we/be/wdata. bus_ready=1 -> drop bus_req,
//   capture lane-extracted bus_rdata (loads), goto RESP. Timer counts BUSY cycles; at
//   TIMEOUT_CYC without bus_ready -> drop bus_req, bus_err_o pulse, goto RESP without resp_valid.
//  RESP: stall_o=0 so pipeline advances at this edge; resp_valid=1 for loads only;
//   req_valid ignored this cycle; next state IDLE. Min latency: request cycle N, bus_req N+1,
//   bus_ready N+1 -> resp_valid N+2 (3 stall-free-inclusive cycles, 2 stalled).
//  Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
//  bus_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
//  Load extract: lane selected by latched addr[1:0], extended per latched req_signed.
//  bus_ready while IDLE/RESP: ignored. bus_ready and timeout in same cycle: ready wins.
// STRUCTURE
//  consts.vh: size encodings (`MEM_SIZE_B/H/W), FSM encodings (`DMEM_IDLE/BUSY/RESP),
//   bus widths reuse `RegDataBus/`RegAddrBus/`InstAddrBus.
//  Sub-module dmem_lane (combinational): alignment check, be/wdata generation, load extract.
//  FSM, timer, output registers in dmem_ctrl.
// TESTING
//  lw 0x100, bus_ready 1 cycle after bus_req, rdata 0xDEADBEEF -> stall 2 cycles, resp 0xDEADBEEF.
//  lb signed 0x103, rdata 0x80112233 -> bus_be 1000, resp_rdata 0xFFFFFF80; lbu -> 0x00000080.
//  sh 0x102 wdata 0x0000ABCD -> bus_be 1100, bus_wdata 0xABCDABCD, bus_we 1, no resp_valid.
//  lw 0x101 -> misalign_o pulse, stall_o 0, bus_req never asserted.
//  bus_ready held 0 -> bus_err_o at BUSY cycle 255, bus_req drops, stall released next cycle.
//  rst low during BUSY -> bus_req 0 same cycle; after release, next lw completes normally.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory controller: access sizes, FSM states, latched request context.
package dmem_ctrl_pkg;

    localparam int unsigned REG_DATA_W  = 32;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned TIMER_W     = 10;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'b00,
        MEM_SIZE_H = 2'b01,
        MEM_SIZE_W = 2'b10,
        MEM_SIZE_X = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'b00,
        DMEM_BUSY = 2'b01,
        DMEM_RESP = 2'b10
    } dmem_state_e;

    // Fields of an accepted request needed to shape the load result.
    typedef struct packed {
        logic      we;
        mem_size_e size;
        logic      sgn;
        logic [1:0] lo;
    } req_ctx_t;

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane logic: alignment check, byte enables, store replication, load extraction.
module dmem_lane
    import dmem_ctrl_pkg::*;
(
    input  mem_size_e              req_size,
    input  logic [1:0]             req_lo,
    input  logic [REG_DATA_W-1:0]  req_wdata,
    output logic                   aligned,
    output logic [3:0]             be,
    output logic [REG_DATA_W-1:0]  wdata_rep,
    input  mem_size_e              ld_size,
    input  logic [1:0]             ld_lo,
    input  logic                   ld_signed,
    input  logic [REG_DATA_W-1:0]  rdata,
    output logic [REG_DATA_W-1:0]  ld_rdata
);

    logic [REG_DATA_W-1:0] shifted;

    always_comb begin
        aligned   = 1'b0;
        be        = '0;
        wdata_rep = req_wdata;
        unique case (req_size)
            MEM_SIZE_B: begin
                aligned   = 1'b1;
                be        = 4'b0001 << req_lo;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            MEM_SIZE_H: begin
                aligned   = ~req_lo[0];
                be        = 4'b0011 << req_lo;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            MEM_SIZE_W: begin
                aligned   = (req_lo == 2'b00);
                be        = 4'b1111;
            end
            default: aligned = 1'b0;
        endcase
    end

    // Shifting the addressed lane down to bit 0 serves both byte and half loads.
    always_comb begin
        shifted  = rdata >> {ld_lo, 3'b000};
        ld_rdata = rdata;
        unique case (ld_size)
            MEM_SIZE_B: ld_rdata = ld_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'b0, shifted[7:0]};
            MEM_SIZE_H: ld_rdata = ld_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'b0, shifted[15:0]};
            default:    ld_rdata = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: IDLE/BUSY/RESP FSM, bus timeout, registered bus and response.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [INST_ADDR_W-1:0]  req_addr,
    input  logic [REG_DATA_W-1:0]   req_wdata,
    input  logic [REG_ADDR_W-1:0]   req_wreg_addr,
    output logic                    stall_o,
    output logic                    resp_valid,
    output logic [REG_DATA_W-1:0]   resp_rdata,
    output logic [REG_ADDR_W-1:0]   resp_wreg_addr,
    output logic                    misalign_o,
    output logic                    bus_err_o,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [INST_ADDR_W-1:0]  bus_addr,
    output logic [REG_DATA_W-1:0]   bus_wdata,
    output logic [3:0]              bus_be,
    input  logic                    bus_ready,
    input  logic [REG_DATA_W-1:0]   bus_rdata
);

    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    dmem_state_e           state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    req_ctx_t              ctx_q, ctx_d;
    logic                  ld_ok_q, ld_ok_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [INST_ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [REG_DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [REG_DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [REG_ADDR_W-1:0] resp_wreg_q, resp_wreg_d;

    logic                  aligned;
    logic [3:0]            lane_be;
    logic [REG_DATA_W-1:0] lane_wdata;
    logic [REG_DATA_W-1:0] ld_rdata;

    dmem_lane u_lane (
        .req_size  (mem_size_e'(req_size)),
        .req_lo    (req_addr[1:0]),
        .req_wdata (req_wdata),
        .aligned   (aligned),
        .be        (lane_be),
        .wdata_rep (lane_wdata),
        .ld_size   (ctx_q.size),
        .ld_lo     (ctx_q.lo),
        .ld_signed (ctx_q.sgn),
        .rdata     (bus_rdata),
        .ld_rdata  (ld_rdata)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        ctx_d        = ctx_q;
        ld_ok_d      = ld_ok_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        resp_rdata_d = resp_rdata_q;
        resp_wreg_d  = resp_wreg_q;
        stall_o      = 1'b0;
        misalign_o   = 1'b0;
        bus_err_o    = 1'b0;

        unique case (state_q)
            DMEM_IDLE: begin
                if (req_valid) begin
                    if (aligned) begin
                        stall_o     = 1'b1;
                        ctx_d       = '{we: req_we, size: mem_size_e'(req_size),
                                        sgn: req_signed, lo: req_addr[1:0]};
                        ld_ok_d     = 1'b0;
                        timer_d     = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {req_addr[INST_ADDR_W-1:2], 2'b00};
                        bus_wdata_d = lane_wdata;
                        bus_be_d    = lane_be;
                        resp_wreg_d = req_wreg_addr;
                        state_d     = DMEM_BUSY;
                    end else begin
                        misalign_o  = 1'b1;
                    end
                end
            end
            DMEM_BUSY: begin
                stall_o = 1'b1;
                // A beat completing on the last allowed cycle still counts as success.
                if (bus_ready) begin
                    bus_req_d = 1'b0;
                    state_d   = DMEM_RESP;
                    if (!ctx_q.we) begin
                        resp_rdata_d = ld_rdata;
                        ld_ok_d      = 1'b1;
                    end
                end else if (timer_q == TMO_LAST) begin
                    bus_req_d = 1'b0;
                    bus_err_o = 1'b1;
                    state_d   = DMEM_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DMEM_RESP: begin
                ld_ok_d = 1'b0;
                state_d = DMEM_IDLE;
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= DMEM_IDLE;
            timer_q      <= '0;
            ctx_q        <= '0;
            ld_ok_q      <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
            resp_rdata_q <= '0;
            resp_wreg_q  <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ctx_q        <= ctx_d;
            ld_ok_q      <= ld_ok_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            resp_rdata_q <= resp_rdata_d;
            resp_wreg_q  <= resp_wreg_d;
        end
    end

    assign resp_valid     = (state_q == DMEM_RESP) && ld_ok_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_wreg_addr = resp_wreg_q;
    assign bus_req        = bus_req_q;
    assign bus_we         = bus_we_q;
    assign bus_addr       = bus_addr_q;
    assign bus_wdata      = bus_wdata_q;
    assign bus_be         = bus_be_q;

endmodule
